dmem_ctrl: RTL and testbench

Data-memory access controller for the RV32I 5-stage pipeline. It sits between the EX/MEM pipeline register and a variable-latency data-memory bus, and sequences every load/store through a req/ack handshake. It generates byte enables and store-data lane placement, and sign/zero-extends load data before it enters MEM/WB. While an access is outstanding it holds the pipeline with `StallM`.

---
 rtl/dmem_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory access controller for the MEM stage of the RV32I pipeline.
// Sequences each load/store through a req/ack bus handshake, places store data on the
// correct byte lanes, extends load data, and stalls the pipeline while an access is open.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   MemReqM, MemWriteM        access request / store select from EX/MEM
//   funct3M, ALUResultM       access size+sign, byte address
//   WriteDataM                right-aligned store data
//   mem_req, mem_we           registered bus request / write enable
//   mem_addr, mem_wdata       registered word address, lane-placed store data
//   mem_be                    registered byte enables
//   mem_ack, mem_err          completion strobe, error (valid with ack)
//   mem_rdata                 read word (valid with ack)
//   StallM                    pipeline hold
//   ReadDataM                 extended load data
//   MisalignM                 misaligned address or illegal funct3
//   BusErrM                   bus error or timeout on the last access
//
// Optional feature: define DMEM_TIMEOUT_EN to abort a BUSY access after TIMEOUT_CYCLES
// cycles without mem_ack.

module dmem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic        mem_err,
    input  logic [31:0] mem_rdata,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        MisalignM,
    output logic        BusErrM
);

    localparam logic [7:0] TimeoutVal = TIMEOUT_CYCLES[7:0];

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic        req_q, we_q, buserr_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  be_q;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;

    logic        legal;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] rdata_shift, load_ext;
    logic        start, complete, abort, stall, misalign, timeout_hit;

    // Request decode: legality, byte enables and lane replication.
    always_comb begin
        legal   = 1'b0;
        be_d    = 4'b0000;
        wdata_d = 32'h0;
        case (funct3M)
            3'b000, 3'b100: begin
                legal   = 1'b1;
                be_d    = 4'b0001 << ALUResultM[1:0];
                wdata_d = {4{WriteDataM[7:0]}};
            end
            3'b001, 3'b101: begin
                legal   = ~ALUResultM[0];
                be_d    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{WriteDataM[15:0]}};
            end
            3'b010: begin
                legal   = (ALUResultM[1:0] == 2'b00);
                be_d    = 4'b1111;
                wdata_d = WriteDataM;
            end
            default: ;
        endcase
    end

    // Load extraction uses the offset/size captured at request time.
    always_comb begin
        rdata_shift = mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b100:  load_ext = {24'h0, rdata_shift[7:0]};
            3'b001:  load_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'b101:  load_ext = {16'h0, rdata_shift[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

`ifdef DMEM_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;

    assign timeout_hit = (state_q == StBusy) && (tmo_cnt_q + 8'd1 == TimeoutVal);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q <= 8'h0;
        end else if (state_q == StBusy && state_d == StBusy) begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end else begin
            tmo_cnt_q <= 8'h0;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TimeoutVal;
`endif

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        stall    = 1'b0;
        misalign = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (MemReqM) begin
                    if (legal) begin
                        start   = 1'b1;
                        stall   = 1'b1;
                        state_d = StBusy;
                    end else begin
                        misalign = 1'b1;
                    end
                end
            end
            StBusy: begin
                stall = 1'b1;
                // A real ack wins over a timeout landing in the same cycle.
                if (mem_ack) begin
                    complete = 1'b1;
                    state_d  = StDone;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            be_q     <= 4'h0;
            off_q    <= 2'b00;
            funct3_q <= 3'b000;
            rdata_q  <= 32'h0;
            buserr_q <= 1'b0;
        end else begin
            if (start) begin
                req_q    <= 1'b1;
                we_q     <= MemWriteM;
                addr_q   <= {ALUResultM[31:2], 2'b00};
                wdata_q  <= wdata_d;
                be_q     <= be_d;
                off_q    <= ALUResultM[1:0];
                funct3_q <= funct3M;
            end
            if (complete) begin
                req_q    <= 1'b0;
                rdata_q  <= (we_q || mem_err) ? 32'h0 : load_ext;
                buserr_q <= mem_err;
            end
            if (abort) begin
                req_q    <= 1'b0;
                rdata_q  <= 32'h0;
                buserr_q <= 1'b1;
            end
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign ReadDataM = rdata_q;
    assign BusErrM   = buserr_q;
    // Combinational outputs are forced low while reset is asserted.
    assign StallM    = rst & stall;
    assign MisalignM = rst & misalign;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReqM, MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack, mem_err;
    logic [31:0] mem_rdata;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        MisalignM, BusErrM;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemReqM    (MemReqM),
        .MemWriteM  (MemWriteM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_err    (mem_err),
        .mem_rdata  (mem_rdata),
        .StallM     (StallM),
        .ReadDataM  (ReadDataM),
        .MisalignM  (MisalignM),
        .BusErrM    (BusErrM)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reference model built from the access rules: size in bytes, alignment by modulo,
    // lane placement by byte index arithmetic.
    task automatic model(input logic [2:0] f3, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input logic err,
                         output logic legal, output logic [3:0] be,
                         output logic [31:0] wdo, output logic [31:0] rdo);
        int size;
        int off;
        longint tmp;
        longint mask;
        off  = int'(addr % 4);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
        legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111) && (size != 0)
                && (off % size == 0);
        be  = 4'h0;
        wdo = 32'h0;
        rdo = 32'h0;
        if (legal) begin
            tmp = ((longint'(1) << size) - 1) << off;
            be  = tmp[3:0];
            for (int i = 0; i < 4; i++) begin
                wdo[8*i +: 8] = wd[8*(i % size) +: 8];
            end
            if (!we && !err) begin
                mask = (longint'(1) << (8 * size)) - 1;
                tmp  = (longint'(rd) >> (8 * off)) & mask;
                if (!f3[2] && size < 4 && tmp[8*size-1]) tmp = tmp | ~mask;
                rdo = tmp[31:0];
            end
        end
    endtask

    // One full access: IDLE detect, delay BUSY cycles (ack on the last), DONE.
    task automatic run_access(input string name, input logic [2:0] f3, input logic we,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input int delay, input logic err,
                              input logic exp_legal, input logic [3:0] exp_be,
                              input logic [31:0] exp_wd, input logic [31:0] exp_rd);
        int stalls;
        @(negedge clk);
        MemReqM = 1'b1; MemWriteM = we; funct3M = f3; ALUResultM = addr; WriteDataM = wd;
        mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = $urandom;
        #1;
        if (!exp_legal) begin
            check({name, " misalign"}, MisalignM, 1'b1);
            check({name, " stall on fault"}, StallM, 1'b0);
            @(negedge clk);
            MemReqM = 1'b0;
            #1;
            check({name, " req after fault"}, mem_req, 1'b0);
            check({name, " misalign one cycle"}, MisalignM, 1'b0);
            return;
        end
        check({name, " no misalign"}, MisalignM, 1'b0);
        stalls = StallM ? 1 : 0;
        for (int k = 1; k <= delay; k++) begin
            @(negedge clk);
            mem_ack   = (k == delay);
            mem_err   = err && (k == delay);
            mem_rdata = (k == delay) ? rd : $urandom;
            #1;
            check({name, " req held"}, mem_req, 1'b1);
            if (k == 1) begin
                check({name, " addr"}, mem_addr, {addr[31:2], 2'b00});
                check({name, " we"}, mem_we, we);
                check({name, " be"}, mem_be, exp_be);
                if (we) check({name, " wdata"}, mem_wdata, exp_wd);
            end
            if (StallM) stalls++;
        end
        @(negedge clk);
        mem_ack = 1'b0; mem_err = 1'b0;
        #1;
        check({name, " done stall"}, StallM, 1'b0);
        check({name, " done req"}, mem_req, 1'b0);
        check({name, " rdata"}, ReadDataM, exp_rd);
        check({name, " buserr"}, BusErrM, err);
        check({name, " stall cycles"}, stalls, delay + 1);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          delay;
        logic        legal;
        logic [3:0]  be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic        m_legal;
        logic [3:0]  m_be;
        logic [31:0] m_wd, m_rd;
        logic [2:0]  f3;
        logic        we, err;
        logic [31:0] addr, wd, rd;
        int          delay;
        int          stalls;

        vecs[0]  = '{3'b010, 1'b0, 32'h100, 32'h0,      32'hDEADBEEF, 1, 1'b1, 4'b1111, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{3'b000, 1'b0, 32'h103, 32'h0,      32'h80112233, 1, 1'b1, 4'b1000, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{3'b100, 1'b0, 32'h103, 32'h0,      32'h80112233, 2, 1'b1, 4'b1000, 32'h0,        32'h00000080};
        vecs[3]  = '{3'b101, 1'b0, 32'h102, 32'h0,      32'h80112233, 1, 1'b1, 4'b1100, 32'h0,        32'h00008011};
        vecs[4]  = '{3'b000, 1'b1, 32'h201, 32'h123456AB, 32'h55555555, 1, 1'b1, 4'b0010, 32'hABABABAB, 32'h0};
        vecs[5]  = '{3'b001, 1'b1, 32'h202, 32'h9876CDEF, 32'h55555555, 3, 1'b1, 4'b1100, 32'hCDEFCDEF, 32'h0};
        vecs[6]  = '{3'b010, 1'b0, 32'h102, 32'h0,      32'h0,        1, 1'b0, 4'b0000, 32'h0,        32'h0};
        vecs[7]  = '{3'b001, 1'b0, 32'h102, 32'h0,      32'h80112233, 1, 1'b1, 4'b1100, 32'h0,        32'hFFFF8011};
        vecs[8]  = '{3'b001, 1'b0, 32'h101, 32'h0,      32'h0,        1, 1'b0, 4'b0000, 32'h0,        32'h0};
        vecs[9]  = '{3'b011, 1'b0, 32'h100, 32'h0,      32'h0,        1, 1'b0, 4'b0000, 32'h0,        32'h0};
        vecs[10] = '{3'b110, 1'b0, 32'h100, 32'h0,      32'h0,        1, 1'b0, 4'b0000, 32'h0,        32'h0};
        vecs[11] = '{3'b010, 1'b1, 32'h104, 32'h12345678, 32'h0,      2, 1'b1, 4'b1111, 32'h12345678, 32'h0};
        vecs[12] = '{3'b000, 1'b0, 32'h100, 32'h0,      32'h1122337F, 1, 1'b1, 4'b0001, 32'h0,        32'h0000007F};

        // Reset state, with requests present to confirm combinational outputs stay low.
        rst = 1'b0;
        MemReqM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h102;
        WriteDataM = 32'h0; mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 32'h0;
        #12;
        check("reset misalign", MisalignM, 1'b0);
        ALUResultM = 32'h100;
        #1;
        check("reset stall", StallM, 1'b0);
        check("reset req", mem_req, 1'b0);
        check("reset we", mem_we, 1'b0);
        check("reset addr", mem_addr, 32'h0);
        check("reset wdata", mem_wdata, 32'h0);
        check("reset be", mem_be, 4'h0);
        check("reset rdata", ReadDataM, 32'h0);
        check("reset buserr", BusErrM, 1'b0);
        MemReqM = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_access($sformatf("vec%0d", i), vecs[i].f3, vecs[i].we, vecs[i].addr,
                       vecs[i].wd, vecs[i].rd, vecs[i].delay, 1'b0, vecs[i].legal,
                       vecs[i].be, vecs[i].exp_wd, vecs[i].exp_rd);
        end

`ifndef DMEM_TIMEOUT_EN
        // Ack after 5 BUSY cycles with an error.
        run_access("lw err", 3'b010, 1'b0, 32'h180, 32'h0, 32'hDEADBEEF, 5, 1'b1,
                   1'b1, 4'b1111, 32'h0, 32'h0);
`else
        // No ack: abort after 4 BUSY cycles, then spurious acks must be ignored.
        @(negedge clk);
        MemReqM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h300;
        mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 32'hCAFEF00D;
        #1;
        stalls = StallM ? 1 : 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            check("tmo req held", mem_req, 1'b1);
            if (StallM) stalls++;
        end
        @(negedge clk);
        mem_ack = 1'b1;
        #1;
        check("tmo stall cycles", stalls, 5);
        check("tmo done stall", StallM, 1'b0);
        check("tmo req dropped", mem_req, 1'b0);
        check("tmo buserr", BusErrM, 1'b1);
        check("tmo rdata", ReadDataM, 32'h0);
        @(negedge clk);
        MemReqM = 1'b0;
        #1;
        check("tmo late ack stall", StallM, 1'b0);
        check("tmo late ack req", mem_req, 1'b0);
        check("tmo late ack buserr", BusErrM, 1'b1);
        @(negedge clk);
        mem_ack = 1'b0;
`endif

        // Reset asserted mid-BUSY drops mem_req without a clock edge.
        @(negedge clk);
        MemReqM = 1'b1; MemWriteM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h400;
        WriteDataM = 32'hA5A5A5A5; mem_ack = 1'b0;
        @(negedge clk);
        #1;
        check("pre-reset req", mem_req, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        check("async reset req", mem_req, 1'b0);
        check("async reset stall", StallM, 1'b0);
        MemReqM = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post-reset stall", StallM, 1'b0);
        check("post-reset req", mem_req, 1'b0);
        run_access("post-reset lw", 3'b010, 1'b0, 32'h404, 32'h0, 32'h01020304, 1, 1'b0,
                   1'b1, 4'b1111, 32'h0, 32'h01020304);

        // Randomized accesses checked against the reference model.
        for (int n = 0; n < 60; n++) begin
            we = ($urandom_range(0, 2) == 0);
            if (we) f3 = 3'($urandom_range(0, 2));
            else if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
            addr  = $urandom;
            wd    = $urandom;
            rd    = $urandom;
            delay = $urandom_range(1, 4);
            err   = ($urandom_range(0, 7) == 0);
            model(f3, we, addr, wd, rd, err, m_legal, m_be, m_wd, m_rd);
            run_access($sformatf("rand%0d", n), f3, we, addr, wd, rd, delay, err,
                       m_legal, m_be, m_wd, m_rd);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                MemReqM = 1'b0;
            end
        end

        @(negedge clk);
        MemReqM = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
